// File: rtl/blink_sequencer.sv
// Turns 1-cycle event pulses into visible LED blink sequences, queueing
// events that arrive mid-sequence (saturating) and playing them back-to-back.
module blink_sequencer #(
  parameter int ON_CLOCKS   = 10000000,
  parameter int OFF_CLOCKS  = 10000000,
  parameter int BLINKS      = 2,
  parameter int MAX_PENDING = 7,
  localparam int PW = $clog2(MAX_PENDING + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          trig,
  input  logic          cancel,
  output logic          led,
  output logic          busy,
  output logic [PW-1:0] pending,
  output logic          overflow,
  output logic [1:0]    state_dbg
);

  localparam int MAXC = (ON_CLOCKS > OFF_CLOCKS) ? ON_CLOCKS : OFF_CLOCKS;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int BW   = (BLINKS > 1) ? $clog2(BLINKS) : 1;

  localparam logic [CW-1:0] ON_LAST    = CW'(ON_CLOCKS - 1);
  localparam logic [CW-1:0] OFF_LAST   = CW'(OFF_CLOCKS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINKS - 1);
  localparam logic [PW-1:0] PEND_MAX   = PW'(MAX_PENDING);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bidx, bidx_n;
  logic [PW-1:0] pend, pend_n;
  logic          ovf, ovf_n;

  logic on_done, off_done, last_blink, seq_end;

  assign on_done    = (cnt == ON_LAST);
  assign off_done   = (cnt == OFF_LAST);
  assign last_blink = (bidx == BLINK_LAST);
  assign seq_end    = (state == OFF) && off_done && last_blink;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      bidx  <= '0;
      pend  <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      bidx  <= bidx_n;
      pend  <= pend_n;
      ovf   <= ovf_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bidx_n  = bidx;
    pend_n  = pend;
    ovf_n   = 1'b0;
    if (cancel) begin
      state_n = IDLE;
      cnt_n   = '0;
      bidx_n  = '0;
      pend_n  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (trig) begin
            state_n = ON;
            cnt_n   = '0;
            bidx_n  = '0;
          end
        end
        ON: begin
          if (on_done) begin
            state_n = OFF;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        OFF: begin
          if (off_done) begin
            cnt_n = '0;
            if (!last_blink) begin
              state_n = ON;
              bidx_n  = bidx + 1'b1;
            end else if ((pend != '0) || trig) begin
              // Chain straight into the next sequence with no idle gap.
              state_n = ON;
              bidx_n  = '0;
            end else begin
              state_n = IDLE;
              bidx_n  = '0;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
          bidx_n  = '0;
          pend_n  = '0;
        end
      endcase

      // Queue bookkeeping while busy. At a sequence end a new trig replaces
      // the popped entry (or is started directly when the queue is empty).
      if (state != IDLE) begin
        if (seq_end) begin
          if ((pend != '0) && !trig) pend_n = pend - 1'b1;
        end else if (trig) begin
          if (pend < PEND_MAX) pend_n = pend + 1'b1;
          else                 ovf_n  = 1'b1;
        end
      end
    end
  end

  assign led       = (state == ON);
  assign busy      = (state != IDLE);
  assign pending   = pend;
  assign overflow  = ovf;
  assign state_dbg = state;

endmodule

// File: tb/tb_blink_sequencer.sv
// Directed bench for blink_sequencer with ON=3, OFF=2, BLINKS=2, MAX_PENDING=2.
// Outputs are sampled on the falling edge; inputs change there too.
module tb_blink_sequencer;

  logic       clk;
  logic       reset_n;
  logic       trig;
  logic       cancel;
  logic       led;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;
  logic [1:0] state_dbg;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  blink_sequencer #(
    .ON_CLOCKS  (3),
    .OFF_CLOCKS (2),
    .BLINKS     (2),
    .MAX_PENDING(2)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .trig     (trig),
    .cancel   (cancel),
    .led      (led),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow),
    .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Sequences run back to back from cycle 1, 10 cycles each: ON 0-2, OFF 3-4,
  // ON 5-7, OFF 8-9 (offsets). 'stop' is the first cycle forced idle.
  function automatic logic exp_busy(input int k, input int nseq, input int stop);
    return (k >= 1) && (k < stop) && (((k - 1) / 10) < nseq);
  endfunction

  function automatic logic exp_led(input int k, input int nseq, input int stop);
    int o;
    if (!exp_busy(k, nseq, stop)) return 1'b0;
    o = (k - 1) % 10;
    return (o < 3) || ((o >= 5) && (o < 8));
  endfunction

  function automatic int exp_pend(input int id, input int k);
    case (id)
      2: begin
        if (k >= 3 && k <= 4)   return 1;
        if (k >= 5 && k <= 10)  return 2;
        if (k >= 11 && k <= 20) return 1;
        return 0;
      end
      3: begin
        if (k == 2)             return 1;
        if (k >= 3 && k <= 10)  return 2;
        if (k >= 11 && k <= 20) return 1;
        return 0;
      end
      4: begin
        if (k >= 3 && k <= 4)   return 1;
        if (k >= 5 && k <= 20)  return 2;
        if (k >= 21 && k <= 30) return 1;
        return 0;
      end
      5: begin
        if (k >= 3 && k <= 7)   return 1;
        return 0;
      end
      default: return 0;
    endcase
  endfunction

  task automatic run_case(input int id, input logic [63:0] tmask, input logic [63:0] cmask,
                          input int nseq, input int stop, input int ncyc);
    for (int k = 0; k <= ncyc; k++) begin
      @(negedge clk);
      cyc = k;
      if (k >= 1) begin
        chk($sformatf("t%0d_led", id), 8'(led), 8'(exp_led(k, nseq, stop)));
        chk($sformatf("t%0d_busy", id), 8'(busy), 8'(exp_busy(k, nseq, stop)));
        chk($sformatf("t%0d_pending", id), 8'(pending), 8'(exp_pend(id, k)));
        chk($sformatf("t%0d_overflow", id), 8'(overflow), 8'((id == 3) && (k == 4)));
      end
      trig   = tmask[k];
      cancel = cmask[k];
    end
    trig   = 1'b0;
    cancel = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_led"}, 8'(led), 8'd0);
    chk({tag, "_busy"}, 8'(busy), 8'd0);
    chk({tag, "_pending"}, 8'(pending), 8'd0);
    chk({tag, "_overflow"}, 8'(overflow), 8'd0);
    chk({tag, "_state"}, 8'(state_dbg), 8'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    trig    = 1'b0;
    cancel  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    reset_n = 1'b1;

    // Cancel while idle is harmless.
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check_idle("idle_cancel");

    // 1: single sequence
    run_case(1, 64'h1, 64'h0, 1, 1000, 14);
    // 2: three events, two queued
    run_case(2, 64'h15, 64'h0, 3, 1000, 34);
    // 3: saturation and one-cycle overflow
    run_case(3, 64'hF, 64'h0, 3, 1000, 34);
    // 4: trig on the pop edge with a full queue
    run_case(4, 64'h415, 64'h0, 4, 1000, 44);
    // 5: cancel with a simultaneous trig
    run_case(5, 64'h85, 64'h80, 2, 8, 20);

    // 6: asynchronous reset in the middle of a sequence
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      cyc = k;
      if (k >= 1) begin
        chk("t6_led", 8'(led), 8'(exp_led(k, 1, 1000)));
        chk("t6_busy", 8'(busy), 8'(exp_busy(k, 1, 1000)));
      end
      trig = (k == 0);
    end
    trig = 1'b0;
    reset_n = 1'b0;
    #1;
    check_idle("t6_async_reset");
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_idle("t6_after_release");
    end
    run_case(1, 64'h1, 64'h0, 1, 1000, 14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
